// File: rtl/cv32e40px_pkg.sv
// Shared types and sizing for the late write-back path into register-file port W2.
package cv32e40px_pkg;

  localparam int WB_ADDR_WIDTH = 6;
  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/cv32e40px_wb_fifo.sv
// Generic flop-based in-order FIFO with flush; exposes its storage and per-slot valid bits
// so a parent can decode what is currently buffered.
module cv32e40px_wb_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            push_data_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            head_o,
  output logic                        empty_o,
  output logic                        full_o,
  output logic [CNT_W-1:0]            count_o,
  output logic [DEPTH-1:0][WIDTH-1:0] entries_o,
  output logic [DEPTH-1:0]            valid_o
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        do_push, do_pop;
  logic [PTR_W-1:0]            offset;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign count_o   = count_q;
  assign head_o    = mem_q[rd_ptr_q];
  assign entries_o = mem_q;
  assign do_push   = push_i & ~full_o;
  assign do_pop    = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Slot i is live when its distance from the read pointer is below the count.
  always_comb begin
    offset  = '0;
    valid_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset     = PTR_W'(i) - rd_ptr_q;
      valid_o[i] = ({1'b0, offset} < count_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cv32e40px_rf_wb_arbiter.sv
// Arbitrates late write-back results onto register-file port W2 through an in-order FIFO,
// yielding to W1 on address collisions and publishing per-register pending bits.
module cv32e40px_rf_wb_arbiter
  import cv32e40px_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int NUM_SRC    = 3,
  parameter int DEPTH      = WB_FIFO_DEPTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush_i,
  input  logic [NUM_SRC-1:0]                   src_valid_i,
  input  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0]   src_addr_i,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]   src_data_i,
  output logic [NUM_SRC-1:0]                   src_ready_o,
  input  logic                                 we_a_i,
  input  logic [ADDR_WIDTH-1:0]                waddr_a_i,
  output logic                                 we_b_o,
  output logic [ADDR_WIDTH-1:0]                waddr_b_o,
  output logic [DATA_WIDTH-1:0]                wdata_b_o,
  output logic [2**ADDR_WIDTH-1:0]             pending_o,
  output logic                                 full_o
);

  // Handshake: a source transfers in any cycle where src_valid_i[i] && src_ready_o[i];
  // ready is granted to the lowest valid index when the FIFO is not full and reset is low,
  // and never waits on flush_i. W2 has no back-pressure: the register file takes we_b_o as issued.

  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [NUM_SRC-1:0]            grant;
  entry_t                        sel_entry;
  entry_t                        head;
  logic                          push, pop, empty, collision;
  logic [DEPTH-1:0][ENTRY_W-1:0] entries;
  logic [DEPTH-1:0]              entry_valid;
  logic [CNT_W-1:0]              count;

  // Descending scan so the lowest valid index is the last writer.
  always_comb begin
    grant     = '0;
    sel_entry = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_valid_i[i]) begin
        grant          = '0;
        grant[i]       = 1'b1;
        sel_entry.addr = src_addr_i[i];
        sel_entry.data = src_data_i[i];
      end
    end
  end

  assign src_ready_o = grant & {NUM_SRC{~full_o & ~rst}};
  // Writes to x0 are acknowledged but never stored.
  assign push        = (|src_valid_i) & ~full_o & (sel_entry.addr != '0);
  assign pop         = ~empty;

  cv32e40px_wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .push_i      (push),
    .push_data_i (sel_entry),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (empty),
    .full_o      (full_o),
    .count_o     (count),
    .entries_o   (entries),
    .valid_o     (entry_valid)
  );

  // W1 carries the younger value, so a colliding head is popped without being written.
  assign collision = we_a_i & (waddr_a_i == head.addr);
  assign we_b_o    = ~empty & ~collision & ~rst;
  assign waddr_b_o = empty ? '0 : head.addr;
  assign wdata_b_o = empty ? '0 : head.data;

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) begin
        pending_o[entries[i][ENTRY_W-1 -: ADDR_WIDTH]] = 1'b1;
      end
    end
    pending_o[0] = 1'b0;
  end

  a_no_valid_during_flush: assert property (
    @(posedge clk) disable iff (rst) flush_i |-> (src_valid_i == '0));

  a_count_bounded: assert property (
    @(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));

endmodule
